// File: rtl/package_sorter.sv
// package_sorter: weight-based package classifier and per-class counter.
// Each clock the 12-bit scale weight is classified into one of six weight
// groups. A package is counted once, on its first nonzero sample after a
// zero sample. currentGrp reports the group of the last sampled weight.
//
// Ports:
//   clk        in   system clock, all state updates on rising edge
//   reset      in   synchronous active-high reset, clears all state
//   weight     in   [11:0] unsigned scale reading, 0 = no package
//   Grp1..Grp6 out  [7:0] per-group package counters (registered)
//   currentGrp out  [2:0] group of last sampled weight, 0 = none (registered)
//
// Build option:
//   PACKAGE_SORTER_SATURATE_EN  defined   -> counters saturate at 255
//                               undefined -> counters wrap modulo 256
module package_sorter (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] weight,
  output logic [7:0]  Grp1,
  output logic [7:0]  Grp2,
  output logic [7:0]  Grp3,
  output logic [7:0]  Grp4,
  output logic [7:0]  Grp5,
  output logic [7:0]  Grp6,
  output logic [2:0]  currentGrp
);

  localparam int unsigned WEIGHT_W = 12;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned GRP_W    = 3;
  localparam int unsigned NUM_GRP  = 6;

  // Inclusive upper bounds of groups 1..5; anything above is group 6.
  localparam logic [WEIGHT_W-1:0] MAX_G1 = WEIGHT_W'(250);
  localparam logic [WEIGHT_W-1:0] MAX_G2 = WEIGHT_W'(500);
  localparam logic [WEIGHT_W-1:0] MAX_G3 = WEIGHT_W'(750);
  localparam logic [WEIGHT_W-1:0] MAX_G4 = WEIGHT_W'(1500);
  localparam logic [WEIGHT_W-1:0] MAX_G5 = WEIGHT_W'(2000);

  logic [CNT_W-1:0] cnt [NUM_GRP];
  logic [GRP_W-1:0] grp_c;
  logic             armed;
  logic             count_c;

  // Combinational weight classification.
  always_comb begin
    grp_c = GRP_W'(0);
    if (weight == '0)          grp_c = GRP_W'(0);
    else if (weight <= MAX_G1) grp_c = GRP_W'(1);
    else if (weight <= MAX_G2) grp_c = GRP_W'(2);
    else if (weight <= MAX_G3) grp_c = GRP_W'(3);
    else if (weight <= MAX_G4) grp_c = GRP_W'(4);
    else if (weight <= MAX_G5) grp_c = GRP_W'(5);
    else                       grp_c = GRP_W'(6);
  end

  // A package counts only on its first nonzero sample after a zero.
  assign count_c = armed && (weight != '0);

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef PACKAGE_SORTER_SATURATE_EN
    bump = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
`else
    bump = v + CNT_W'(1);
`endif
  endfunction

  // State: counters, armed flag and registered current group.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_GRP; i++) cnt[i] <= '0;
      armed      <= 1'b1;
      currentGrp <= '0;
    end else begin
      armed      <= (weight == '0);
      currentGrp <= grp_c;
      for (int i = 0; i < NUM_GRP; i++) begin
        if (count_c && (grp_c == GRP_W'(i + 1))) cnt[i] <= bump(cnt[i]);
      end
    end
  end

  assign Grp1 = cnt[0];
  assign Grp2 = cnt[1];
  assign Grp3 = cnt[2];
  assign Grp4 = cnt[3];
  assign Grp5 = cnt[4];
  assign Grp6 = cnt[5];

endmodule

// File: tb/tb_package_sorter.sv
// Testbench for package_sorter: directed test-plan steps plus randomized
// traffic, checked against a behavioural model of the sorting rules.
module tb_package_sorter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] weight = '0;
  logic [7:0]  Grp1, Grp2, Grp3, Grp4, Grp5, Grp6;
  logic [2:0]  currentGrp;

  int total = 0;
  int bad   = 0;

  // Behavioural reference state.
  int  m_cnt [6];
  bit  m_armed;
  int  m_cur;

  package_sorter dut (
    .clk        (clk),
    .reset      (reset),
    .weight     (weight),
    .Grp1       (Grp1),
    .Grp2       (Grp2),
    .Grp3       (Grp3),
    .Grp4       (Grp4),
    .Grp5       (Grp5),
    .Grp6       (Grp6),
    .currentGrp (currentGrp)
  );

  always #5 clk = ~clk;

  function automatic int classify(input int w);
    if (w == 0)     return 0;
    if (w <= 250)   return 1;
    if (w <= 500)   return 2;
    if (w <= 750)   return 3;
    if (w <= 1500)  return 4;
    if (w <= 2000)  return 5;
    return 6;
  endfunction

  function automatic int add_one(input int v);
`ifdef PACKAGE_SORTER_SATURATE_EN
    return (v >= 255) ? 255 : v + 1;
`else
    return (v + 1) % 256;
`endif
  endfunction

  task automatic model_reset();
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_armed = 1'b1;
    m_cur   = 0;
  endtask

  task automatic model_step(input int w);
    int g;
    g = classify(w);
    if (w != 0 && m_armed) m_cnt[g-1] = add_one(m_cnt[g-1]);
    m_armed = (w == 0);
    m_cur   = g;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "/Grp1"}, 32'(Grp1), 32'(m_cnt[0]));
    chk({tag, "/Grp2"}, 32'(Grp2), 32'(m_cnt[1]));
    chk({tag, "/Grp3"}, 32'(Grp3), 32'(m_cnt[2]));
    chk({tag, "/Grp4"}, 32'(Grp4), 32'(m_cnt[3]));
    chk({tag, "/Grp5"}, 32'(Grp5), 32'(m_cnt[4]));
    chk({tag, "/Grp6"}, 32'(Grp6), 32'(m_cnt[5]));
    chk({tag, "/cur"},  32'(currentGrp), 32'(m_cur));
  endtask

  // One functional clock: drive, clock, update model, sample #1 after edge.
  task automatic step(input int w, input string tag);
    reset  = 1'b0;
    weight = 12'(w);
    @(posedge clk);
    #1;
    model_step(w);
    chk_model(tag);
  endtask

  task automatic do_reset(input int w, input int edges);
    reset  = 1'b1;
    weight = 12'(w);
    repeat (edges) @(posedge clk);
    #1;
    model_reset();
    chk_model("reset");
  endtask

  int seq_w   [12] = '{100, 0, 250, 0, 550, 0, 801, 0, 1001, 0, 2001, 0};
  int seq_cur [12] = '{1, 0, 1, 0, 3, 0, 4, 0, 4, 0, 6, 0};
  int bnd_w   [11] = '{250, 251, 500, 501, 750, 751, 1500, 1501, 2000, 2001, 4095};
  int bnd_cur [11] = '{1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 6};
  int edge_vals [12] = '{1, 250, 251, 500, 501, 750, 751, 1500, 1501, 2000, 2001, 4095};

  initial begin
    int w;
    int ovf_exp;

    // Reset held with a package on the scale, then released.
    do_reset(500, 2);
    chk("rst/Grp2", 32'(Grp2), 32'd0);
    chk("rst/cur", 32'(currentGrp), 32'd0);
    step(500, "rst_release");
    chk("rst_release/Grp2", 32'(Grp2), 32'd1);
    chk("rst_release/cur", 32'(currentGrp), 32'd2);

    // Basic sequence from reset.
    do_reset(0, 1);
    for (int i = 0; i < 12; i++) begin
      step(seq_w[i], "seq");
      chk("seq/cur_const", 32'(currentGrp), 32'(seq_cur[i]));
    end
    chk("seq/Grp1", 32'(Grp1), 32'd2);
    chk("seq/Grp2", 32'(Grp2), 32'd0);
    chk("seq/Grp3", 32'(Grp3), 32'd1);
    chk("seq/Grp4", 32'(Grp4), 32'd2);
    chk("seq/Grp5", 32'(Grp5), 32'd0);
    chk("seq/Grp6", 32'(Grp6), 32'd1);

    // Group boundaries separated by zeros.
    do_reset(0, 1);
    for (int i = 0; i < 11; i++) begin
      step(bnd_w[i], "bnd");
      chk("bnd/cur_const", 32'(currentGrp), 32'(bnd_cur[i]));
      step(0, "bnd_gap");
    end
    chk("bnd/Grp1", 32'(Grp1), 32'd1);
    chk("bnd/Grp2", 32'(Grp2), 32'd2);
    chk("bnd/Grp3", 32'(Grp3), 32'd2);
    chk("bnd/Grp4", 32'(Grp4), 32'd2);
    chk("bnd/Grp5", 32'(Grp5), 32'd2);
    chk("bnd/Grp6", 32'(Grp6), 32'd2);

    // Held and changing package counts once.
    do_reset(0, 1);
    step(0, "held");
    step(150, "held");
    chk("held/cur1", 32'(currentGrp), 32'd1);
    step(150, "held");
    step(300, "held");
    chk("held/cur2", 32'(currentGrp), 32'd2);
    step(300, "held");
    step(0, "held");
    chk("held/cur0", 32'(currentGrp), 32'd0);
    chk("held/Grp1", 32'(Grp1), 32'd1);
    chk("held/Grp2", 32'(Grp2), 32'd0);

    // Counter overflow on 256 packages.
    do_reset(0, 1);
    for (int i = 0; i < 256; i++) begin
      step(100, "ovf");
      step(0, "ovf_gap");
    end
`ifdef PACKAGE_SORTER_SATURATE_EN
    ovf_exp = 255;
`else
    ovf_exp = 0;
`endif
    chk("ovf/Grp1", 32'(Grp1), 32'(ovf_exp));

    // Reset pulsed mid-package.
    do_reset(0, 1);
    step(900, "mid");
    chk("mid/Grp4_a", 32'(Grp4), 32'd1);
    do_reset(900, 1);
    chk("mid/Grp4_rst", 32'(Grp4), 32'd0);
    step(900, "mid");
    chk("mid/Grp4_b", 32'(Grp4), 32'd1);

    // Randomized traffic with occasional resets.
    do_reset(0, 1);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3: w = 0;
        4, 5:       w = edge_vals[$urandom_range(11)];
        default:    w = int'($urandom_range(4095, 1));
      endcase
      if ($urandom_range(99) == 0) do_reset(w, 1);
      else step(w, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
